// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped, write-back, write-allocate data
// cache controller (dcache_ctrl) and its line storage (dcache_array).
//   - cache geometry (DC_LINES lines of DC_WORDS 32-bit words) and the
//     derived address field widths
//   - controller state enum
//   - line record {valid, dirty, tag, data[WORDS]}
//   - saturating increment helper for the optional statistics counters
// Byte address layout: {tag, idx, off, 2'b00}.
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int unsigned DC_LINES = 16;
  localparam int unsigned DC_WORDS = 4;

  localparam int unsigned OFF_W = $clog2(DC_WORDS);
  localparam int unsigned IDX_W = $clog2(DC_LINES);
  localparam int unsigned TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  typedef struct packed {
    logic                         valid;
    logic                         dirty;
    logic [TAG_W-1:0]             tag;
    logic [DC_WORDS-1:0][31:0]    data;
  } line_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// -----------------------------------------------------------------------------
// dcache_array
// Line storage for dcache_ctrl: DEPTH lines of line_t, one whole-line write
// port and an asynchronous (combinational) read by index.
// Reset clears only the valid and dirty bits; tags and data keep whatever
// they held.
// Ports:
//   i_clk     clock
//   i_reset   synchronous active-high reset
//   i_we      write enable for the line at i_widx
//   i_widx    write index
//   i_wline   full line value to write
//   i_ridx    read index
//   o_rline   line currently stored at i_ridx
// -----------------------------------------------------------------------------
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = DC_LINES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  line_t            i_wline,
  input  logic [IDX_W-1:0] i_ridx,
  output line_t            o_rline
);

  line_t r_mem [DEPTH];

  // Line write port; reset invalidates and cleans every line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i].valid <= 1'b0;
        r_mem[i].dirty <= 1'b0;
      end
    end else if (i_we) begin
      r_mem[i_widx] <= i_wline;
    end
  end

  assign o_rline = r_mem[i_ridx];

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller sitting in
// the M pipeline stage. Hits complete combinationally in the same cycle
// (CacheReady=1); misses optionally write the dirty victim back word by word,
// then refill the line word by word over a req/ack memory port, and finally
// replay the access as a hit in IDLE.
//
// Optional build macro: CACHE_STATS_EN adds saturating HitCount/MissCount
// outputs. Without it those ports and counters do not exist.
//
// Ports:
//   CLK         clock
//   reset       synchronous active-high reset
//   MemReadM    load in M stage
//   MemWriteM   store in M stage (wins when both are high)
//   AddrM       byte address, bits [1:0] ignored; held while CacheReady=0
//   WriteDataM  store data
//   ReadDataM   load data, valid when CacheReady & MemReadM
//   CacheReady  access complete / no access pending
//   MemReq      main-memory word request
//   MemWe       1 = write word, 0 = read word
//   MemAddr     word-aligned main-memory address
//   MemWData    write data to memory
//   MemAck      memory accepted/returned one word this cycle
//   MemRData    read data, valid with MemAck & ~MemWe
//   HitCount    (CACHE_STATS_EN) hits in IDLE, excluding post-refill replay
//   MissCount   (CACHE_STATS_EN) IDLE -> WRITEBACK/ALLOCATE transitions
// LINES/WORDS must match DC_LINES/DC_WORDS in dcache_pkg, which fix the
// line record layout.
// -----------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = DC_LINES,
  parameter int unsigned WORDS = DC_WORDS
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        CacheReady,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam logic [OFF_W-1:0] CNT_ZERO = OFF_W'(0);
  localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [OFF_W-1:0] r_cnt;
  logic [OFF_W-1:0] w_cnt_nxt;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [1:0]       w_unused_addr_lsb;
  logic             w_access;
  logic             w_hit;

  line_t            w_line;
  line_t            w_wline;
  logic             w_we;

  assign w_off             = AddrM[2 +: OFF_W];
  assign w_idx             = AddrM[2 + OFF_W +: IDX_W];
  assign w_tag             = AddrM[31 -: TAG_W];
  assign w_unused_addr_lsb = AddrM[1:0];
  assign w_access          = MemReadM | MemWriteM;
  assign w_hit             = w_line.valid & (w_line.tag == w_tag);

  // The M stage is stalled during a miss, so AddrM (and therefore w_idx)
  // keeps pointing at the victim line for the whole transfer.
  dcache_array #(
    .DEPTH (LINES)
  ) u_array (
    .i_clk   (CLK),
    .i_reset (reset),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wline (w_wline),
    .i_ridx  (w_idx),
    .o_rline (w_line)
  );

  // State and word counter registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, line update and all outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_wline     = w_line;
    CacheReady  = 1'b0;
    ReadDataM   = 32'd0;
    MemReq      = 1'b0;
    MemWe       = 1'b0;
    MemAddr     = 32'd0;
    MemWData    = 32'd0;

    case (r_state)
      IDLE: begin
        if (!w_access) begin
          CacheReady = 1'b1;
        end else if (w_hit) begin
          CacheReady = 1'b1;
          if (MemWriteM) begin
            w_wline.data[w_off] = WriteDataM;
            w_wline.dirty       = 1'b1;
            w_we                = 1'b1;
          end else begin
            ReadDataM = w_line.data[w_off];
          end
        end else begin
          w_cnt_nxt = CNT_ZERO;
          if (w_line.valid && w_line.dirty) begin
            w_state_nxt = WRITEBACK;
          end else begin
            w_state_nxt = ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        MemReq   = 1'b1;
        MemWe    = 1'b1;
        MemAddr  = {w_line.tag, w_idx, r_cnt, 2'b00};
        MemWData = w_line.data[r_cnt];
        if (MemAck) begin
          // Counter wraps to zero exactly when the last word is accepted.
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_wline.dirty = 1'b0;
            w_we          = 1'b1;
            w_state_nxt   = ALLOCATE;
          end else begin
            w_state_nxt = WRITEBACK;
          end
        end else begin
          w_state_nxt = WRITEBACK;
        end
      end

      ALLOCATE: begin
        MemReq  = 1'b1;
        MemWe   = 1'b0;
        MemAddr = {w_tag, w_idx, r_cnt, 2'b00};
        if (MemAck) begin
          w_wline.data[r_cnt] = MemRData;
          w_we                = 1'b1;
          w_cnt_nxt           = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_wline.valid = 1'b1;
            w_wline.dirty = 1'b0;
            w_wline.tag   = w_tag;
            w_state_nxt   = IDLE;
          end else begin
            w_state_nxt = ALLOCATE;
          end
        end else begin
          w_state_nxt = ALLOCATE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  logic        r_replay;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_hit_evt;
  logic        w_miss_evt;

  assign w_hit_evt  = (r_state == IDLE) & w_access & w_hit & ~r_replay;
  assign w_miss_evt = (r_state == IDLE) & w_access & ~w_hit;

  // Statistics; r_replay marks the first IDLE cycle after a refill so the
  // replayed access is not also counted as a hit.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_replay   <= 1'b0;
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      r_replay <= (r_state == ALLOCATE) && (w_state_nxt == IDLE);
      if (w_hit_evt) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end
      if (w_miss_evt) begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  assign HitCount  = r_hit_cnt;
  assign MissCount = r_miss_cnt;
`endif

endmodule
